// File: rtl/dcache_lookup_ctrl_pkg.sv
// Shared cache geometry, line type and word-select helper for the load lookup controller.
package dcache_lookup_ctrl_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_TAG_WIDTH    = 44;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_LINE_WIDTH   = 128;
  localparam int unsigned WORD_SEL_WIDTH      = DCACHE_OFFSET_WIDTH - 3;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]  tag;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic                         valid;
  } cache_line_t;

  function automatic logic [63:0] word_of(input logic [DCACHE_LINE_WIDTH-1:0] line,
                                          input logic [WORD_SEL_WIDTH-1:0]    sel);
    return line[{sel, 6'd0} +: 64];
  endfunction

endpackage

// File: rtl/dcache_lookup_ctrl_lzc.sv
// Trailing-zero counter: turns a hit vector into the index of its lowest set way.
module dcache_lookup_ctrl_lzc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 empty
);

  always_comb begin
    cnt = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bits[i]) cnt = CNT_WIDTH'(i);
    end
  end

  assign empty = ~|bits;

endmodule

// File: rtl/dcache_lookup_ctrl.sv
// Load lookup controller in front of one tag_cmp port: read, compare, miss hand-off, replay.
//   state       | meaning
//   IDLE        | ready for a new index
//   WAIT_GNT    | SRAM read requested, waiting for grant
//   CMP         | read data and hit vector valid, tag compared
//   WAIT_TAG    | translation late, waiting for tag before re-reading
//   MISS_REQ    | miss request presented to the miss unit
//   WAIT_REFILL | waiting for refill, then replay (or drop if killed)
module dcache_lookup_ctrl
  import dcache_lookup_ctrl_pkg::*;
#(
  parameter int unsigned NR_WAYS    = 8,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [DCACHE_INDEX_WIDTH-1:0] req_index_i,
  input  logic                          tag_valid_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]   tag_i,
  input  logic                          kill_i,
  output logic                          rsp_valid_o,
  output logic [63:0]                   rsp_data_o,
  output logic [NR_WAYS-1:0]            sram_req_o,
  output logic [ADDR_WIDTH-1:0]         sram_addr_o,
  output logic                          sram_we_o,
  input  logic                          sram_gnt_i,
  output logic [DCACHE_TAG_WIDTH-1:0]   sram_tag_o,
  input  logic [NR_WAYS-1:0]            hit_way_i,
  input  cache_line_t [NR_WAYS-1:0]     rdata_i,
  output logic                          miss_req_o,
  input  logic                          miss_gnt_i,
  output logic [ADDR_WIDTH-1:0]         miss_addr_o,
  input  logic                          miss_done_i
);

  localparam int unsigned WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_GNT, CMP, WAIT_TAG, MISS_REQ, WAIT_REFILL} state_e;

  state_e                         state_q, state_d;
  logic [DCACHE_INDEX_WIDTH-1:0]  index_q, index_d;
  logic [DCACHE_TAG_WIDTH-1:0]    tag_q, tag_d, cmp_tag;
  logic                           tag_vld_q, tag_vld_d;
  logic                           killed_q, killed_d;
  logic [WAY_W-1:0]               way_idx;
  logic                           no_hit;

  dcache_lookup_ctrl_lzc #(.WIDTH(NR_WAYS), .CNT_WIDTH(WAY_W)) u_lzc (
    .bits  (hit_way_i),
    .cnt   (way_idx),
    .empty (no_hit)
  );

  assign cmp_tag     = tag_vld_q ? tag_q : tag_i;
  assign sram_we_o   = 1'b0;
  assign sram_addr_o = ADDR_WIDTH'(index_q);
  assign miss_addr_o = ADDR_WIDTH'({tag_q, index_q[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH],
                                    {DCACHE_OFFSET_WIDTH{1'b0}}});
  assign rsp_data_o  = word_of(rdata_i[way_idx].data, index_q[DCACHE_OFFSET_WIDTH-1:3]);

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    tag_d       = tag_q;
    tag_vld_d   = tag_vld_q;
    killed_d    = killed_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    sram_req_o  = '0;
    sram_tag_o  = tag_q;
    miss_req_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        killed_d    = 1'b0;
        if (req_valid_i) begin
          index_d   = req_index_i;
          tag_vld_d = 1'b0;
          state_d   = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        sram_req_o = '1;
        if (kill_i)          state_d = IDLE;
        else if (sram_gnt_i) state_d = CMP;
      end
      CMP: begin
        sram_tag_o = cmp_tag;
        if (kill_i) begin
          state_d = IDLE;
        end else if (!tag_vld_q && !tag_valid_i) begin
          state_d = WAIT_TAG;
        end else if (!no_hit) begin
          rsp_valid_o = 1'b1;
          state_d     = IDLE;
        end else begin
          tag_d     = cmp_tag;
          tag_vld_d = 1'b1;
          state_d   = MISS_REQ;
        end
      end
      // The read in flight used no tag, so its data is stale: read again once the tag lands.
      WAIT_TAG: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (tag_valid_i) begin
          tag_d     = tag_i;
          tag_vld_d = 1'b1;
          state_d   = WAIT_GNT;
        end
      end
      MISS_REQ: begin
        miss_req_o = 1'b1;
        if (miss_gnt_i) begin
          killed_d = kill_i;
          state_d  = WAIT_REFILL;
        end else if (kill_i) begin
          state_d = IDLE;
        end
      end
      WAIT_REFILL: begin
        if (miss_done_i)  state_d = (killed_q || kill_i) ? IDLE : WAIT_GNT;
        else if (kill_i)  killed_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      index_q   <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      killed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      killed_q  <= killed_d;
    end
  end

  a_hit_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (state_q == CMP) |-> $onehot0(hit_way_i));

endmodule
